// File: rtl/jogo_memoria_param_pkg.sv
// Shared definitions for the memory game: FSM state codes and the LFSR
// that generates the symbol sequence.
package jogo_memoria_param_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA_ON   = 4'h2,
    MOSTRA_OFF  = 4'h3,
    PROX_MOSTRA = 4'h4,
    ESPERA      = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    PROX_JOGADA = 4'h8,
    PROX_RODADA = 4'h9,
    GANHOU      = 4'hA,
    PERDEU      = 4'hB
  } estado_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [7:0] lfsr_passo(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_contador.sv
// Modulo-M cycle counter with synchronous clear; fim flags the last counted
// cycle so the FSM can leave a state after exactly M cycles.
module contador_param
  import jogo_memoria_param_pkg::*;
#(
  parameter int M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] valor_q;
  logic [W-1:0] valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = (valor_q == ULTIMO) ? '0 : valor_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign fim = conta && (valor_q == ULTIMO);

endmodule

// File: rtl/jogo_memoria_param.sv
// Simon-style memory game: shows a growing LFSR-generated sequence on the
// LEDs (or plays blind) and checks the player's button presses against it.
module jogo_memoria_param
  import jogo_memoria_param_pkg::*;
#(
  parameter int         N_BOTOES     = 4,
  parameter int         PROFUNDIDADE = 16,
  parameter int         T_ON         = 1000,
  parameter int         T_OFF        = 500,
  parameter int         T_TIMEOUT    = 5000,
  parameter logic [7:0] SEMENTE      = 8'hA5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                memoria,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic                timeout,
  output logic [3:0]          db_estado,
  output logic [7:0]          db_endereco,
  output logic [7:0]          db_rodada,
  output logic [N_BOTOES-1:0] db_jogada
);

  localparam int                IDX_W         = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
  localparam logic [7:0]        SEED          = SEMENTE;
  localparam logic [7:0]        ULTIMA_RODADA = 8'(PROFUNDIDADE - 1);
  localparam logic [N_BOTOES-1:0] UM          = N_BOTOES'(1);

  estado_t             estado_q;
  logic [N_BOTOES-1:0] leds_q;
  logic                ganhou_q, perdeu_q, pronto_q, timeout_q;
  logic [7:0]          endereco_q, rodada_q;
  logic [N_BOTOES-1:0] jogada_q;
  logic [N_BOTOES-1:0] botoes_q;
  logic [7:0]          lfsr_q;
  logic                modo_q;

  logic [7:0]          lfsr_prox;
  logic [N_BOTOES-1:0] simbolo_atual, simbolo_prox, simbolo_semente;
  logic                inicio, jogada_borda, jogada_ok;
  logic                fim_on, fim_off, fim_timeout;

  assign lfsr_prox       = lfsr_passo(lfsr_q);
  assign simbolo_atual   = UM << lfsr_q[IDX_W-1:0];
  assign simbolo_prox    = UM << lfsr_prox[IDX_W-1:0];
  assign simbolo_semente = UM << SEED[IDX_W-1:0];

  assign inicio = jogar && (estado_q == INICIAL || estado_q == GANHOU || estado_q == PERDEU);

  // botoes_q follows the buttons even during reset, so a press held across
  // reset release never looks like a fresh edge.
  assign jogada_borda = (|botoes) && !(|botoes_q);
  assign jogada_ok    = (jogada_q != '0) && ((jogada_q & (jogada_q - UM)) == '0)
                        && (jogada_q == simbolo_atual);

  contador_param #(.M(T_ON)) u_t_on (
    .clock (clock),
    .reset (reset),
    .zera  (inicio),
    .conta (estado_q == MOSTRA_ON),
    .fim   (fim_on)
  );

  contador_param #(.M(T_OFF)) u_t_off (
    .clock (clock),
    .reset (reset),
    .zera  (inicio),
    .conta (estado_q == MOSTRA_OFF),
    .fim   (fim_off)
  );

  contador_param #(.M(T_TIMEOUT)) u_t_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (inicio || estado_q == REGISTRA),
    .conta (estado_q == ESPERA),
    .fim   (fim_timeout)
  );

  always_ff @(posedge clock) begin
    botoes_q <= botoes;
    if (reset) begin
      estado_q   <= INICIAL;
      leds_q     <= '0;
      ganhou_q   <= 1'b0;
      perdeu_q   <= 1'b0;
      pronto_q   <= 1'b0;
      timeout_q  <= 1'b0;
      endereco_q <= 8'd0;
      rodada_q   <= 8'd0;
      jogada_q   <= '0;
      lfsr_q     <= SEED;
      modo_q     <= 1'b0;
    end else begin
      case (estado_q)
        INICIAL, GANHOU, PERDEU: begin
          if (jogar) begin
            estado_q   <= PREPARA;
            rodada_q   <= 8'd0;
            endereco_q <= 8'd0;
            ganhou_q   <= 1'b0;
            perdeu_q   <= 1'b0;
            pronto_q   <= 1'b0;
            timeout_q  <= 1'b0;
            modo_q     <= memoria;
          end
        end
        PREPARA: begin
          lfsr_q <= SEED;
          if (modo_q) begin
            estado_q <= MOSTRA_ON;
            leds_q   <= simbolo_semente;
          end else begin
            estado_q <= ESPERA;
          end
        end
        MOSTRA_ON: begin
          if (fim_on) begin
            estado_q <= MOSTRA_OFF;
            leds_q   <= '0;
          end
        end
        MOSTRA_OFF: begin
          if (fim_off) estado_q <= PROX_MOSTRA;
        end
        PROX_MOSTRA: begin
          if (endereco_q == rodada_q) begin
            endereco_q <= 8'd0;
            lfsr_q     <= SEED;
            estado_q   <= ESPERA;
          end else begin
            endereco_q <= endereco_q + 8'd1;
            lfsr_q     <= lfsr_prox;
            leds_q     <= simbolo_prox;
            estado_q   <= MOSTRA_ON;
          end
        end
        ESPERA: begin
          // A press landing on the final timeout cycle takes priority.
          if (jogada_borda) begin
            estado_q <= REGISTRA;
          end else if (fim_timeout) begin
            estado_q  <= PERDEU;
            perdeu_q  <= 1'b1;
            pronto_q  <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        REGISTRA: begin
          jogada_q <= botoes;
          estado_q <= COMPARA;
        end
        COMPARA: begin
          if (!jogada_ok) begin
            estado_q <= PERDEU;
            perdeu_q <= 1'b1;
            pronto_q <= 1'b1;
          end else if (endereco_q < rodada_q) begin
            estado_q <= PROX_JOGADA;
          end else begin
            estado_q <= PROX_RODADA;
          end
        end
        PROX_JOGADA: begin
          endereco_q <= endereco_q + 8'd1;
          lfsr_q     <= lfsr_prox;
          estado_q   <= ESPERA;
        end
        PROX_RODADA: begin
          if (rodada_q == ULTIMA_RODADA) begin
            estado_q <= GANHOU;
            ganhou_q <= 1'b1;
            pronto_q <= 1'b1;
          end else begin
            rodada_q   <= rodada_q + 8'd1;
            endereco_q <= 8'd0;
            lfsr_q     <= SEED;
            if (modo_q) begin
              estado_q <= MOSTRA_ON;
              leds_q   <= simbolo_semente;
            end else begin
              estado_q <= ESPERA;
            end
          end
        end
        default: estado_q <= INICIAL;
      endcase
    end
  end

  assign leds        = leds_q;
  assign ganhou      = ganhou_q;
  assign perdeu      = perdeu_q;
  assign pronto      = pronto_q;
  assign timeout     = timeout_q;
  assign db_estado   = estado_q;
  assign db_endereco = endereco_q;
  assign db_rodada   = rodada_q;
  assign db_jogada   = jogada_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param: single-play vector table plus
// full-game, wrong-play and reset sequences.
module tb_jogo_memoria_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic       memoria = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic [3:0] leds;
  logic       ganhou, perdeu, pronto, timeout;
  logic [3:0] db_estado;
  logic [7:0] db_endereco, db_rodada;
  logic [3:0] db_jogada;

  int vetores = 0;
  int erros   = 0;

  // Sequence from seed A5, taps B8: A5, EA, 75, 82 -> low 2 bits 1, 2, 1, 2.
  logic [3:0] sym [4];

  typedef struct {
    logic       modo;
    int         atraso;
    logic [3:0] tecla;
    logic [3:0] e_estado;
    logic [3:0] e_leds;
    logic       e_perdeu;
    logic       e_timeout;
    logic [7:0] e_rodada;
    logic [3:0] e_jogada;
  } vetor_t;

  vetor_t tab [9];

  jogo_memoria_param #(
    .N_BOTOES(4), .PROFUNDIDADE(4), .T_ON(3), .T_OFF(2), .T_TIMEOUT(10), .SEMENTE(8'hA5)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .memoria(memoria), .botoes(botoes),
    .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .timeout(timeout),
    .db_estado(db_estado), .db_endereco(db_endereco), .db_rodada(db_rodada),
    .db_jogada(db_jogada)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    vetores++;
    if (got !== exp) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic aplicar_reset();
    @(negedge clock);
    reset = 1'b1;
    jogar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic iniciar(input logic modo);
    @(negedge clock);
    jogar   = 1'b1;
    memoria = modo;
    @(negedge clock);
    jogar = 1'b0;
  endtask

  task automatic esperar_estado(input logic [3:0] alvo, input int limite);
    int n = 0;
    while (db_estado !== alvo && n < limite) begin
      @(negedge clock);
      n++;
    end
    chk("wait_state", db_estado, alvo);
  endtask

  // Press held through REGISTRA, released in COMPARA; returns 4 edges later.
  task automatic jogar_tecla(input logic [3:0] tecla);
    botoes = tecla;
    @(negedge clock);
    @(negedge clock);
    botoes = 4'b0000;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic ver_exibicao(input int k);
    int on  = 0;
    int off = 0;
    esperar_estado(4'h2, 20);
    while (db_estado == 4'h2 && on < 8) begin
      chk("leds_on", leds, sym[k]);
      on++;
      @(negedge clock);
    end
    while (db_estado == 4'h3 && off < 8) begin
      chk("leds_off", leds, 4'b0000);
      off++;
      @(negedge clock);
    end
    chk("on_cycles", on, 3);
    chk("off_cycles", off, 2);
    $display("display k=%0d sym=%b on=%0d off=%0d", k, sym[k], on, off);
  endtask

  task automatic jogo_completo(input logic modo);
    for (int r = 0; r < 4; r++) begin
      if (modo) for (int k = 0; k <= r; k++) ver_exibicao(k);
      esperar_estado(4'h5, 30);
      for (int k = 0; k <= r; k++) begin
        jogar_tecla(sym[k]);
        if (k < r)      chk("state_next_play", db_estado, 4'h5);
        else if (r < 3) chk("state_next_round", db_estado, modo ? 4'h2 : 4'h5);
        else            chk("state_win", db_estado, 4'hA);
        if (!modo) chk("leds_blind", leds, 4'b0000);
        chk("round", db_rodada, (k == r && r < 3) ? r + 1 : r);
        $display("play mode=%0d round=%0d k=%0d key=%b state=%h", modo, r, k, sym[k], db_estado);
      end
    end
    chk("ganhou", ganhou, 1);
    chk("pronto", pronto, 1);
    chk("perdeu", perdeu, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sym[0] = 4'b0010; sym[1] = 4'b0100; sym[2] = 4'b0010; sym[3] = 4'b0100;
    //           modo atraso tecla    estado leds     perd to  rodada jogada
    tab[0] = '{1'b0, 0,  4'b0010, 4'h5, 4'b0000, 1'b0, 1'b0, 8'd1, 4'b0010};
    tab[1] = '{1'b0, 0,  4'b0100, 4'hB, 4'b0000, 1'b1, 1'b0, 8'd0, 4'b0100};
    tab[2] = '{1'b0, 0,  4'b0011, 4'hB, 4'b0000, 1'b1, 1'b0, 8'd0, 4'b0011};
    tab[3] = '{1'b0, 9,  4'b0010, 4'h5, 4'b0000, 1'b0, 1'b0, 8'd1, 4'b0010};
    tab[4] = '{1'b0, 10, 4'b0010, 4'hB, 4'b0000, 1'b1, 1'b1, 8'd0, 4'b0000};
    tab[5] = '{1'b0, 3,  4'b1000, 4'hB, 4'b0000, 1'b1, 1'b0, 8'd0, 4'b1000};
    tab[6] = '{1'b0, 5,  4'b0001, 4'hB, 4'b0000, 1'b1, 1'b0, 8'd0, 4'b0001};
    tab[7] = '{1'b1, 0,  4'b0010, 4'h2, 4'b0010, 1'b0, 1'b0, 8'd1, 4'b0010};
    tab[8] = '{1'b0, 0,  4'b0000, 4'h5, 4'b0000, 1'b0, 1'b0, 8'd0, 4'b0000};

    // Reset values, with a button held across reset release.
    botoes = 4'b0010;
    aplicar_reset();
    chk("rst_state", db_estado, 4'h0);
    chk("rst_leds", leds, 4'b0000);
    chk("rst_flags", {ganhou, perdeu, pronto, timeout}, 4'b0000);
    chk("rst_addr", db_endereco, 8'd0);
    chk("rst_round", db_rodada, 8'd0);
    chk("rst_jogada", db_jogada, 4'b0000);
    iniciar(1'b0);
    esperar_estado(4'h5, 10);
    repeat (3) @(negedge clock);
    chk("held_press_ignored", db_estado, 4'h5);
    botoes = 4'b0000;
    $display("reset check and held-press check done");

    for (int i = 0; i < 9; i++) begin
      aplicar_reset();
      iniciar(tab[i].modo);
      esperar_estado(4'h5, 60);
      repeat (tab[i].atraso) @(negedge clock);
      jogar_tecla(tab[i].tecla);
      chk("vec_state", db_estado, tab[i].e_estado);
      chk("vec_leds", leds, tab[i].e_leds);
      chk("vec_perdeu", perdeu, tab[i].e_perdeu);
      chk("vec_pronto", pronto, tab[i].e_perdeu);
      chk("vec_timeout", timeout, tab[i].e_timeout);
      chk("vec_ganhou", ganhou, 0);
      chk("vec_round", db_rodada, tab[i].e_rodada);
      chk("vec_jogada", db_jogada, tab[i].e_jogada);
      $display("vector %0d: mode=%0d delay=%0d key=%b -> state=%h perdeu=%0d timeout=%0d",
               i, tab[i].modo, tab[i].atraso, tab[i].tecla, db_estado, perdeu, timeout);
    end

    // Mode 1 full game.
    aplicar_reset();
    iniciar(1'b1);
    jogo_completo(1'b1);

    // Mode 1, wrong symbol on the second play of round 2.
    aplicar_reset();
    iniciar(1'b1);
    ver_exibicao(0);
    esperar_estado(4'h5, 20);
    jogar_tecla(sym[0]);
    ver_exibicao(0);
    ver_exibicao(1);
    esperar_estado(4'h5, 20);
    jogar_tecla(sym[0]);
    chk("r2_first_ok", db_estado, 4'h5);
    botoes = 4'b1000;
    @(negedge clock);
    chk("wrong_registra", db_estado, 4'h6);
    @(negedge clock);
    chk("wrong_compara", db_estado, 4'h7);
    botoes = 4'b0000;
    @(negedge clock);
    chk("wrong_perdeu_state", db_estado, 4'hB);
    chk("wrong_perdeu", perdeu, 1);
    chk("wrong_timeout", timeout, 0);
    chk("wrong_pronto", pronto, 1);
    $display("wrong play in round 2: state=%h perdeu=%0d", db_estado, perdeu);

    // Mode 0 full game, restart from GANHOU, then reset mid-game.
    aplicar_reset();
    iniciar(1'b0);
    jogo_completo(1'b0);
    iniciar(1'b0);
    chk("restart_state", db_estado, 4'h1);
    chk("restart_flags", {ganhou, perdeu, pronto, timeout}, 4'b0000);
    esperar_estado(4'h5, 10);
    jogar_tecla(sym[0]);
    chk("restart_round", db_rodada, 8'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midplay_rst_state", db_estado, 4'h0);
    chk("midplay_rst_outs", {leds, ganhou, perdeu, pronto, timeout}, 8'h00);
    chk("midplay_rst_cnt", {db_rodada, db_endereco}, 16'h0000);
    chk("midplay_rst_jogada", db_jogada, 4'b0000);
    $display("mid-play reset: state=%h", db_estado);

    // Reset during the display phase.
    iniciar(1'b1);
    esperar_estado(4'h2, 10);
    chk("display_leds_before_rst", leds, sym[0]);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("middisp_rst_state", db_estado, 4'h0);
    chk("middisp_rst_leds", leds, 4'b0000);
    $display("mid-display reset: state=%h leds=%b", db_estado, leds);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/jogo_memoria_param.md
JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 Parameter N_BOTOES, default 4: number of buttons/LEDs; power of two, 2..8.
REQ-002 Parameter PROFUNDIDADE, default 16: number of rounds (maximum sequence length); 2..256.
REQ-003 Parameter T_ON, default 1000: LED-on cycles per displayed symbol; at least 1.
REQ-004 Parameter T_OFF, default 500: LED-off gap cycles between symbols; at least 1.
REQ-005 Parameter T_TIMEOUT, default 5000: cycles allowed per play; at least 1.
REQ-006 Parameter SEMENTE, default 8'hA5: nonzero LFSR seed.
REQ-007 clock  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 jogar  in  1  start request; sampled only in INICIAL, GANHOU or PERDEU.
REQ-010 memoria  in  1  mode, latched at start: 1 = display sequence each round; 0 = blind (no display).
REQ-011 botoes  in  N_BOTOES  player buttons, level, already synchronised.
REQ-012 leds  out  N_BOTOES  one-hot symbol during display-on; zero otherwise.
REQ-013 ganhou / perdeu / pronto / timeout  out  1 each  win, loss, game over (win or loss), loss cause was timeout.
REQ-014 db_estado  out  4  state code; db_endereco, db_rodada  out  8  address and round counters; db_jogada  out  N_BOTOES  last registered play.

Function
REQ-015 Sequence symbol k is the one-hot of the low log2(N_BOTOES) bits of an 8-bit Galois LFSR (taps 0xB8) after k steps from SEMENTE; the LFSR is reloaded with SEMENTE at the start of every display pass and every play pass.
REQ-016 States and codes: INICIAL 0, PREPARA 1, MOSTRA_ON 2, MOSTRA_OFF 3, PROX_MOSTRA 4, ESPERA 5, REGISTRA 6, COMPARA 7, PROX_JOGADA 8, PROX_RODADA 9, GANHOU A, PERDEU B.
REQ-017 INICIAL/GANHOU/PERDEU with jogar=1 -> PREPARA: zero round, address and timers; clear flags; latch memoria.
REQ-018 PREPARA -> MOSTRA_ON if mode=1, else ESPERA.
REQ-019 MOSTRA_ON holds leds for exactly T_ON cycles, then MOSTRA_OFF holds zero for exactly T_OFF cycles, then PROX_MOSTRA.
REQ-020 PROX_MOSTRA: if address == round, zero address, reload LFSR, go to ESPERA; else increment address, step LFSR, go to MOSTRA_ON.
REQ-021 A play is a 0->nonzero edge of botoes; presses held from earlier states do not count.
REQ-022 In ESPERA, the cycle after a play edge is REGISTRA: botoes is stored in db_jogada and the timeout counter is cleared. The next cycle is COMPARA.
REQ-023 COMPARA: db_jogada not one-hot, or not equal to the current symbol -> PERDEU. Correct and address < round -> PROX_JOGADA (increment address, step LFSR, return to ESPERA). Correct and address == round -> PROX_RODADA.
REQ-024 PROX_RODADA: if round == PROFUNDIDADE-1 -> GANHOU. Otherwise increment round, zero address, reload LFSR, then MOSTRA_ON (mode 1) or ESPERA (mode 0).
REQ-025 The timeout counter runs only in ESPERA. On reaching T_TIMEOUT cycles without a play edge -> PERDEU with timeout=1. If a play edge arrives in the same cycle the count is reached, the play wins.
REQ-026 GANHOU asserts ganhou=1 and pronto=1; PERDEU asserts perdeu=1 and pronto=1. Both outputs and the timeout flag hold until the next start or reset.
REQ-027 Round counter and address are 8 bits wide and never wrap; compares are unsigned.

Reset
REQ-028 A reset cycle forces INICIAL from any state, including mid-display or mid-play.
REQ-029 Reset values: leds, ganhou, perdeu, pronto and timeout are 0; db_estado is 0; all counters are 0; db_jogada is 0; the LFSR holds SEMENTE; the latched mode is 0.
REQ-030 In the first cycle after reset is released, buttons already held do not count as a play edge.

Structure
REQ-031 A shared package holds the state codes and the LFSR tap constant.
REQ-032 A single sub-module, contador_param (modulo M, zera, conta, fim), is used for the T_ON, T_OFF and T_TIMEOUT timers; the FSM, comparison and LFSR stay in the top module.

Verification
REQ-033 Use N_BOTOES=4, PROFUNDIDADE=4, T_ON=3, T_OFF=2, T_TIMEOUT=10 for all scenarios.
REQ-034 Mode 1, correct plays every round -> leds show 1, 2, 3, 4 symbols in successive rounds, each on for 3 cycles and off for 2; ganhou=pronto=1 after the 10th correct play.
REQ-035 Mode 1, wrong symbol in round 2 -> PERDEU two cycles after the play edge; perdeu=1, timeout=0, db_estado=B.
REQ-036 No press for 10 cycles in ESPERA -> perdeu=1, timeout=1; a press on cycle 10 -> no loss.
REQ-037 Press botoes=4'b0011 -> PERDEU (not one-hot).
REQ-038 Mode 0 full win -> leds stay 0 throughout; ganhou=1. Then reset asserted mid-game -> INICIAL next cycle with all outputs 0.
